// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, stall indices, HI/LO func codes, ALU select bits and bus layout
package ex_stage_pkg;
  localparam int ID_TO_EX_WD = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD = 38;
  localparam int STALL_WD = 6;
  localparam int STALL_EX = 2;
  localparam int STALL_MEM = 3;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV = 6'h1A;
  localparam logic [5:0] F_DIVU = 6'h1B;
  localparam int OP_ADD = 11;
  localparam int OP_SUB = 10;
  localparam int OP_SLT = 9;
  localparam int OP_SLTU = 8;
  localparam int OP_AND = 7;
  localparam int OP_NOR = 6;
  localparam int OP_OR = 5;
  localparam int OP_XOR = 4;
  localparam int OP_SLL = 3;
  localparam int OP_SRL = 2;
  localparam int OP_SRA = 1;
  localparam int OP_LUI = 0;
  localparam int S1_RS = 2;
  localparam int S1_PC = 1;
  localparam int S1_SA = 0;
  localparam int S2_RT = 3;
  localparam int S2_SIMM = 2;
  localparam int S2_EIGHT = 1;
  localparam int S2_ZIMM = 0;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0] src1_sel;
    logic [3:0] src2_sel;
    logic ram_en;
    logic [3:0] ram_wen;
    logic rf_we;
    logic [4:0] rf_waddr;
    logic sel_rf_res;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
  } id_ex_t;
endpackage

// File: rtl/ex_stage_div_iter.sv
// div_iter: 32-step restoring divider with magnitude capture and signed fixup
module div_iter
  import ex_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic start,
  input logic sign_op,
  input logic advance,
  input logic [31:0] a,
  input logic [31:0] b,
  output logic busy,
  output logic done,
  output logic [31:0] quot,
  output logic [31:0] rem
);
  div_state_t state;
  logic [4:0] cnt;
  logic [31:0] q, r, d;
  logic neg_q, neg_r;
  logic [32:0] sh, diff;
  assign sh = {r, q[31]};
  assign diff = sh - {1'b0, d};
  assign busy = ~rst & ((state == D_IDLE & start) | state == D_RUN);
  assign done = state == D_DONE;
  assign quot = neg_q ? -q : q;
  assign rem = neg_r ? -r : r;
  // capture magnitudes on entry, shift-subtract one bit per cycle, wait in DONE for the pipeline
  always_ff @(posedge clk)
    if (rst) begin
      state <= D_IDLE;
      cnt <= 5'd0;
      q <= 32'd0;
      r <= 32'd0;
      d <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else
      case (state)
        D_IDLE: if (start) begin
          state <= D_RUN;
          cnt <= 5'd0;
          q <= sign_op & a[31] ? -a : a;
          d <= sign_op & b[31] ? -b : b;
          r <= 32'd0;
          neg_q <= sign_op & (a[31] ^ b[31]);
          neg_r <= sign_op & a[31];
        end
        D_RUN: begin
          q <= {q[30:0], ~diff[32]};
          r <= diff[32] ? sh[31:0] : diff[31:0];
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= D_DONE;
        end
        D_DONE: if (advance) state <= D_IDLE;
        default: state <= D_IDLE;
      endcase
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, HI/LO, iterative divider and data-SRAM requests
module ex_stage
  import ex_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic [STALL_WD-1:0] stall,
  input logic [ID_TO_EX_WD-1:0] id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0] ex_to_rf_bus,
  output logic ex_is_load,
  output logic stallreq_for_ex,
  output logic data_sram_en,
  output logic [3:0] data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);
  id_ex_t ex;
  logic [31:0] hi, lo, src1, src2, sra_res, alu_res, ex_result, quot, rem;
  logic [63:0] prod_s, prod_u;
  logic hilo_op, is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic advance, div_done, unused_ok;
  assign advance = stall[STALL_EX] == NO_STOP;
  // EX register: bubble when EX stops but MEM moves on, hold when both stop
  always_ff @(posedge clk)
    if (rst) ex <= '0;
    else if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP) ex <= '0;
    else if (advance) ex <= id_to_ex_bus;
  assign hilo_op = ex.inst[31:26] == 6'd0;
  assign is_mult = hilo_op & (ex.inst[5:0] == F_MULT);
  assign is_multu = hilo_op & (ex.inst[5:0] == F_MULTU);
  assign is_div = hilo_op & (ex.inst[5:0] == F_DIV);
  assign is_divu = hilo_op & (ex.inst[5:0] == F_DIVU);
  assign is_mfhi = hilo_op & (ex.inst[5:0] == F_MFHI);
  assign is_mflo = hilo_op & (ex.inst[5:0] == F_MFLO);
  assign is_mthi = hilo_op & (ex.inst[5:0] == F_MTHI);
  assign is_mtlo = hilo_op & (ex.inst[5:0] == F_MTLO);
  assign src1 = ({32{ex.src1_sel[S1_RS]}} & ex.rs_data)
    | ({32{ex.src1_sel[S1_PC]}} & ex.pc)
    | ({32{ex.src1_sel[S1_SA]}} & {27'd0, ex.inst[10:6]});
  assign src2 = ({32{ex.src2_sel[S2_RT]}} & ex.rt_data)
    | ({32{ex.src2_sel[S2_SIMM]}} & {{16{ex.inst[15]}}, ex.inst[15:0]})
    | ({32{ex.src2_sel[S2_EIGHT]}} & 32'd8)
    | ({32{ex.src2_sel[S2_ZIMM]}} & {16'd0, ex.inst[15:0]});
  assign sra_res = $signed(src2) >>> src1[4:0];
  assign alu_res = ({32{ex.alu_op[OP_ADD]}} & (src1 + src2))
    | ({32{ex.alu_op[OP_SUB]}} & (src1 - src2))
    | ({32{ex.alu_op[OP_SLT]}} & {31'd0, $signed(src1) < $signed(src2)})
    | ({32{ex.alu_op[OP_SLTU]}} & {31'd0, src1 < src2})
    | ({32{ex.alu_op[OP_AND]}} & (src1 & src2))
    | ({32{ex.alu_op[OP_NOR]}} & ~(src1 | src2))
    | ({32{ex.alu_op[OP_OR]}} & (src1 | src2))
    | ({32{ex.alu_op[OP_XOR]}} & (src1 ^ src2))
    | ({32{ex.alu_op[OP_SLL]}} & (src2 << src1[4:0]))
    | ({32{ex.alu_op[OP_SRL]}} & (src2 >> src1[4:0]))
    | ({32{ex.alu_op[OP_SRA]}} & sra_res)
    | ({32{ex.alu_op[OP_LUI]}} & {src2[15:0], 16'd0});
  assign prod_s = $signed(ex.rs_data) * $signed(ex.rt_data);
  assign prod_u = {32'd0, ex.rs_data} * {32'd0, ex.rt_data};
  div_iter u_div (
    .clk(clk),
    .rst(rst),
    .start(is_div | is_divu),
    .sign_op(is_div),
    .advance(advance),
    .a(ex.rs_data),
    .b(ex.rt_data),
    .busy(stallreq_for_ex),
    .done(div_done),
    .quot(quot),
    .rem(rem)
  );
  // HI/LO commit only when the instruction leaves EX, so a stalled op never writes twice
  always_ff @(posedge clk)
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (advance) begin
      if (is_mult) {hi, lo} <= prod_s;
      else if (is_multu) {hi, lo} <= prod_u;
      else if ((is_div | is_divu) & div_done) begin
        hi <= rem;
        lo <= quot;
      end else if (is_mthi) hi <= ex.rs_data;
      else if (is_mtlo) lo <= ex.rs_data;
    end
  assign ex_result = is_mfhi ? hi : is_mflo ? lo : alu_res;
  assign ex_to_mem_bus = {ex.pc, ex.ram_en, ex.ram_wen, ex.sel_rf_res, ex.rf_we, ex.rf_waddr, ex_result};
  assign ex_to_rf_bus = {ex.rf_we, ex.rf_waddr, ex_result};
  assign ex_is_load = ex.ram_en & ex.sel_rf_res;
  assign data_sram_en = ~stallreq_for_ex & (ex.ram_en | (|ex.ram_wen));
  assign data_sram_wen = stallreq_for_ex ? 4'h0 : {4{|ex.ram_wen}};
  assign data_sram_addr = stallreq_for_ex ? 32'd0 : ex_result;
  assign data_sram_wdata = stallreq_for_ex ? 32'd0 : ex.rt_data;
  assign unused_ok = ^{stall[5:4], stall[1:0], ex.inst[25:16]};
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_ex_stage;
  import ex_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] stall_tb = 6'd0;
  logic [5:0] stall;
  logic [158:0] id_bus = '0;
  logic [75:0] ex_to_mem_bus;
  logic [37:0] ex_to_rf_bus;
  logic ex_is_load, stallreq_for_ex, data_sram_en;
  logic [3:0] data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  typedef struct {int cyc; string name; logic [184:0] v;} exp_t;
  exp_t sbq[$];
  exp_t e;
  logic [184:0] act;

  assign stall = stallreq_for_ex ? 6'b011111 : stall_tb;
  assign act = {stallreq_for_ex, ex_is_load, ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata};

  ex_stage dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .id_to_ex_bus(id_bus),
    .ex_to_mem_bus(ex_to_mem_bus),
    .ex_to_rf_bus(ex_to_rf_bus),
    .ex_is_load(ex_is_load),
    .stallreq_for_ex(stallreq_for_ex),
    .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL %s: sample slot %0d missed", e.name, e.cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  end

  function automatic logic [11:0] oh(input int b);
    return 12'd1 << b;
  endfunction

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic ren, input logic [3:0] wen, input logic we,
      input logic [4:0] wa, input logic sel, input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, rs, rt};
  endfunction

  function automatic logic [184:0] expv(input logic [158:0] bus, input logic [31:0] res, input logic sr);
    logic [75:0] mb;
    mb = {bus[158:127], bus[75], bus[74:71], bus[64], bus[70], bus[69:65], res};
    return {sr, bus[75] & bus[64], mb, mb[37:0], ~sr & (bus[75] | (|bus[74:71])),
            sr ? 4'h0 : {4{|bus[74:71]}}, sr ? 32'd0 : res, sr ? 32'd0 : bus[31:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push_now(input string name, input logic [184:0] v);
    sbq.push_back('{cyc, name, v});
  endtask

  task automatic run(input string name, input logic [158:0] bus, input logic [31:0] res, input logic sr);
    id_bus = bus;
    @(posedge clk);
    #1;
    push_now(name, expv(bus, res, sr));
    id_bus = '0;
  endtask

  function automatic logic [158:0] hl(input logic [5:0] f, input logic we, input logic [31:0] rs, input logic [31:0] rt);
    return mk(32'hBFC0_0200, {6'h0, 5'd4, 5'd5, 5'd10, 5'd0, f}, 12'd0, 3'd0, 4'd0, 1'b0, 4'h0, we, we ? 5'd10 : 5'd0, 1'b0, rs, rt);
  endfunction

  task automatic alu(input string name, input int op, input int s1, input int s2, input logic [15:0] imm,
      input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] res);
    run(name, mk(pc, {6'h08, 5'd1, 5'd2, imm}, oh(op), 3'd1 << s1, 4'd1 << s2, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, rs, rt), res, 1'b0);
  endtask

  task automatic do_div(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] lo_e, input logic [31:0] hi_e);
    int n;
    run({name, "_issue"}, hl(sgn ? F_DIV : F_DIVU, 1'b0, a, b), 32'd0, 1'b1);
    n = 0;
    while (stallreq_for_ex === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({name, "_stall_cycles"}, n, 33);
    run({name, "_mflo"}, hl(F_MFLO, 1'b1, 32'd0, 32'd0), lo_e, 1'b0);
    run({name, "_mfhi"}, hl(F_MFHI, 1'b1, 32'd0, 32'd0), hi_e, 1'b0);
  endtask

  logic [158:0] addiu_bus;

  initial begin
    addiu_bus = mk(32'hBFC0_0000, {6'h09, 5'd3, 5'd9, 16'hFFFF}, oh(OP_ADD), 3'd1 << S1_RS, 4'd1 << S2_SIMM,
                   1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'd5, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    push_now("reset_outputs", '0);
    rst = 1'b0;
    run("mfhi_after_reset", hl(F_MFHI, 1'b1, 32'd0, 32'd0), 32'd0, 1'b0);
    run("mflo_after_reset", hl(F_MFLO, 1'b1, 32'd0, 32'd0), 32'd0, 1'b0);
    run("addiu", addiu_bus, 32'd4, 1'b0);
    run("sw", mk(32'hBFC0_0004, {6'h2B, 5'd3, 5'd9, 16'h0008}, oh(OP_ADD), 3'd1 << S1_RS, 4'd1 << S2_SIMM,
                 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF), 32'h0000_1008, 1'b0);
    run("lw", mk(32'hBFC0_0008, {6'h23, 5'd3, 5'd8, 16'hFFFC}, oh(OP_ADD), 3'd1 << S1_RS, 4'd1 << S2_SIMM,
                 1'b1, 4'h0, 1'b1, 5'd8, 1'b1, 32'h0000_2000, 32'h55), 32'h0000_1FFC, 1'b0);
    alu("sub", OP_SUB, S1_RS, S2_RT, 16'h0, 32'h0, 32'd10, 32'd3, 32'd7);
    alu("slt", OP_SLT, S1_RS, S2_RT, 16'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu("sltu", OP_SLTU, S1_RS, S2_RT, 16'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu("and", OP_AND, S1_RS, S2_RT, 16'h0, 32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu("nor", OP_NOR, S1_RS, S2_RT, 16'h0, 32'h0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
    alu("or", OP_OR, S1_RS, S2_RT, 16'h0, 32'h0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    alu("xor", OP_XOR, S1_RS, S2_RT, 16'h0, 32'h0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu("sll", OP_SLL, S1_SA, S2_RT, 16'h0100, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h10);
    alu("srl", OP_SRL, S1_SA, S2_RT, 16'h0100, 32'h0, 32'h0, 32'h8000_0000, 32'h0800_0000);
    alu("sra", OP_SRA, S1_SA, S2_RT, 16'h0100, 32'h0, 32'h0, 32'h8000_0000, 32'hF800_0000);
    alu("lui", OP_LUI, S1_RS, S2_ZIMM, 16'h1234, 32'h0, 32'h0, 32'h0, 32'h1234_0000);
    alu("jal_link", OP_ADD, S1_PC, S2_EIGHT, 16'h0, 32'hBFC0_0100, 32'h0, 32'h0, 32'hBFC0_0108);
    alu("ori", OP_OR, S1_RS, S2_ZIMM, 16'h8001, 32'h0, 32'h00FF_0000, 32'h0, 32'h00FF_8001);
    run("hold_load", addiu_bus, 32'd4, 1'b0);
    id_bus = mk(32'h0, 32'h0, oh(OP_ADD), 3'd1 << S1_RS, 4'd1 << S2_RT, 1'b1, 4'hF, 1'b1, 5'd7, 1'b0, 32'd1, 32'd1);
    stall_tb = 6'b001111;
    @(posedge clk);
    #1;
    push_now("hold", expv(addiu_bus, 32'd4, 1'b0));
    stall_tb = 6'b000111;
    @(posedge clk);
    #1;
    push_now("bubble", '0);
    stall_tb = 6'd0;
    id_bus = '0;
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div("divu_by0", 1'b0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000);
    run("multu", hl(F_MULTU, 1'b0, 32'hFFFF_FFFF, 32'd2), 32'd0, 1'b0);
    run("multu_mfhi", hl(F_MFHI, 1'b1, 32'd0, 32'd0), 32'd1, 1'b0);
    run("multu_mflo", hl(F_MFLO, 1'b1, 32'd0, 32'd0), 32'hFFFF_FFFE, 1'b0);
    run("mult", hl(F_MULT, 1'b0, 32'hFFFF_FFFD, 32'd5), 32'd0, 1'b0);
    run("mult_mfhi", hl(F_MFHI, 1'b1, 32'd0, 32'd0), 32'hFFFF_FFFF, 1'b0);
    run("mult_mflo", hl(F_MFLO, 1'b1, 32'd0, 32'd0), 32'hFFFF_FFF1, 1'b0);
    run("mthi", hl(F_MTHI, 1'b0, 32'h0000_ABCD, 32'd0), 32'd0, 1'b0);
    run("mtlo", hl(F_MTLO, 1'b0, 32'h0000_1234, 32'd0), 32'd0, 1'b0);
    run("mthi_mfhi", hl(F_MFHI, 1'b1, 32'd0, 32'd0), 32'h0000_ABCD, 1'b0);
    run("mtlo_mflo", hl(F_MFLO, 1'b1, 32'd0, 32'd0), 32'h0000_1234, 1'b0);
    run("abort_issue", hl(F_DIV, 1'b0, 32'd100, 32'd7), 32'd0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_before_rst", {31'd0, stallreq_for_ex}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_now("abort_rst", '0);
    run("abort_mfhi", hl(F_MFHI, 1'b1, 32'd0, 32'd0), 32'd0, 1'b0);
    run("abort_mflo", hl(F_MFLO, 1'b1, 32'd0, 32'd0), 32'd0, 1'b0);
    do_div("div_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes the 159-bit decode-to-execute bus and latches it into its own pipeline register.
- Computes the ALU result and issues data-SRAM load/store requests.
- Forwards its writeback candidate back to decode.
- Owns HI/LO with single-cycle mult/multu and an iterative 32-cycle div/divu that stalls the pipeline.

Parameters:
- ID_TO_EX_WD, 159, decode-to-execute bus width.
- EX_TO_MEM_WD, 76, execute-to-memory bus width.
- EX_TO_RF_WD, 38, forwarding bus width {we, waddr[4:0], wdata[31:0]}.
- STALL_WD, 6, stall vector width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  6  per-stage stop vector, 1=Stop; bit2=EX register, bit3=MEM register
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], src1_sel[82:80], src2_sel[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_data[63:32], rt_data[31:0]}
- ex_to_mem_bus  out  76  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- ex_to_rf_bus  out  38  forwarding to decode
- ex_is_load  out  1  EX holds a load; decode uses it for load-use stall
- stallreq_for_ex  out  1  divider busy
- data_sram_en  out  1  SRAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  SRAM address
- data_sram_wdata  out  32  store data

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset:
  - EX register, HI and LO clear to 0.
  - Divider goes to IDLE.
  - All outputs are 0, since they derive from a zeroed register.
- EX register update each posedge:
  - rst: load 0.
  - stall[2]=Stop and stall[3]=NoStop: load 0 (bubble).
  - stall[2]=NoStop: load id_to_ex_bus.
  - Otherwise hold.
- ALU, combinational:
  - src1 one-hot: rs_data, pc, or zero-extended inst[10:6].
  - src2 one-hot: rt_data, sign-extended imm, 32'd8, or zero-extended imm.
  - alu_op one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src1[4:0] as the amount and src2 as the value; lui gives {imm,16'b0}.
  - All-zero select yields 0. Arithmetic wraps, with no overflow trap.
- HI/LO group, decoded from inst with opcode 0:
  - func 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
  - func 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo.
  - ex_result is HI for mfhi and LO for mflo; rf_we for these comes from decode.
- HI/LO writes on the edge where stall[2]=NoStop:
  - mult/multu: full 64-bit product, {HI,LO}=product.
  - mthi/mtlo: take rs_data.
  - div/divu: writes on that edge only when the divider is in DONE.
- Divider FSM (sub-module):
  - IDLE→RUN: the first cycle a div/divu sits in EX. Operands are captured as magnitudes for signed div; stallreq_for_ex=1 from this cycle.
  - RUN: one restoring iteration per cycle, 32 cycles, stallreq_for_ex=1.
  - RUN→DONE: after the 32nd iteration. stallreq_for_ex=0 in DONE.
  - DONE→IDLE: on the edge where stall[2]=NoStop, which is the same edge that writes HI/LO.
  - Total: 33 cycles in EX when unstalled downstream.
- Divider result rules:
  - Signed sign fix: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Divide by zero raises no trap: LO=0xFFFFFFFF, HI=dividend (unsigned magnitudes, sign fix still applied).
- Memory interface:
  - data_sram_en = ram_en | (|ram_wen).
  - data_sram_wen = 4'hF if |ram_wen, else 0 (word only).
  - data_sram_addr = ex_result.
  - data_sram_wdata = rt_data.
  - Memory outputs are forced to 0 while stallreq_for_ex=1.
- ex_to_rf_bus = {rf_we, rf_waddr, ex_result}; ex_is_load = ram_en & sel_rf_res.
- rst during RUN aborts to IDLE, leaves HI/LO at 0 and drops stallreq the same cycle.

Decomposition:
- Shared defines header: bus widths, stall bit indices, Stop/NoStop, func codes for the HI/LO group, alu_op bit positions.
- One sub-module, div_iter: operand latch, 32-step restoring divider, signed fixup, 3-state FSM, outputs busy/done/quot/rem.

Test Plan:
- addiu: rs_data=5, imm=0xFFFF → ex_result=4, ex_to_rf_bus={1, rt, 4}, one-cycle latency after the EX register load.
- sw: base=0x1000, imm=8, rt_data=0xDEADBEEF → data_sram_en=1, wen=F, addr=0x1008, wdata=0xDEADBEEF.
- div -7/2, then mflo and mfhi: stallreq high for exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; mflo in EX the next cycle outputs 0xFFFFFFFD.
- divu 0x80000000/0 → LO=0xFFFFFFFF, HI=0x80000000. multu 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
- Stall bubble: stall=6'b000111 → next EX content is zero, so ex_to_rf_bus we=0 and data_sram_en=0.
- rst pulse at RUN iteration 10 → FSM IDLE, stallreq=0 and HI/LO=0 next cycle; a following div completes normally in 33 cycles.
